// File: rtl/flt_op_sequencer_if.sv
// Host-side bundle for flt_op_sequencer: operation request, data-memory port,
// processor-core handshake and status outputs.
interface flt_op_sequencer_if;
  logic        go;
  logic [15:0] flt1;
  logic [15:0] flt2;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  logic        start;
  logic        ack;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        timeout_err;
  logic [15:0] cycle_ct;

  modport master (
    output go, flt1, flt2, mem_rd_data, ack,
    input  mem_wr_en, mem_addr, mem_wr_data, start, result, result_valid,
           busy, timeout_err, cycle_ct
  );

  modport slave (
    input  go, flt1, flt2, mem_rd_data, ack,
    output mem_wr_en, mem_addr, mem_wr_data, start, result, result_valid,
           busy, timeout_err, cycle_ct
  );
endinterface

// File: rtl/flt_op_sequencer.sv
// Sequences one fp16 add on an external core: stores both operands to data
// memory, pulses start, waits for the ack rising edge and reads the sum back.
module flt_op_sequencer #(
  parameter int unsigned TIMEOUT  = 2500,
  parameter int unsigned OP_BASE  = 8,
  parameter int unsigned RES_BASE = 12
) (
  input logic              clk,
  input logic              reset,
  flt_op_sequencer_if.slave bus
);
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 16;
  localparam int unsigned CW = 16;

  typedef enum logic [3:0] {
    IDLE, WR0, WR1, WR2, WR3, START, WAIT, RD_LO, RD_HI, DONE
  } state_t;

  state_t        state;
  logic [FW-1:0] flt1_q;
  logic [FW-1:0] flt2_q;
  logic          ack_q;
  logic          start_q;
  logic          mem_wr_en_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wr_data_q;
  logic [FW-1:0] result_q;
  logic          result_valid_q;
  logic          busy_q;
  logic          timeout_err_q;
  logic [CW-1:0] cycle_ct_q;

  logic          ack_rise_c;
  logic [CW-1:0] cycle_ct_inc_c;
  logic          timeout_hit_c;

  assign ack_rise_c     = bus.ack & ~ack_q;
  assign cycle_ct_inc_c = (cycle_ct_q == '1) ? cycle_ct_q : cycle_ct_q + CW'(1);
  // Abort when the count this WAIT cycle produces reaches the limit
  assign timeout_hit_c  = 32'(cycle_ct_inc_c) >= TIMEOUT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      flt1_q         <= '0;
      flt2_q         <= '0;
      ack_q          <= 1'b0;
      start_q        <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      cycle_ct_q     <= '0;
    end else begin
      ack_q          <= bus.ack;
      start_q        <= 1'b0;
      mem_wr_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wr_data_q  <= '0;
      result_valid_q <= 1'b0;

      // Outputs are loaded with the values belonging to the state being entered
      case (state)
        IDLE: begin
          if (bus.go) begin
            state         <= WR0;
            flt1_q        <= bus.flt1;
            flt2_q        <= bus.flt2;
            cycle_ct_q    <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b1;
            mem_wr_en_q   <= 1'b1;
            mem_addr_q    <= AW'(OP_BASE);
            mem_wr_data_q <= bus.flt1[7:0];
          end
        end
        WR0: begin
          state         <= WR1;
          mem_wr_en_q   <= 1'b1;
          mem_addr_q    <= AW'(OP_BASE + 32'd1);
          mem_wr_data_q <= flt1_q[15:8];
        end
        WR1: begin
          state         <= WR2;
          mem_wr_en_q   <= 1'b1;
          mem_addr_q    <= AW'(OP_BASE + 32'd2);
          mem_wr_data_q <= flt2_q[7:0];
        end
        WR2: begin
          state         <= WR3;
          mem_wr_en_q   <= 1'b1;
          mem_addr_q    <= AW'(OP_BASE + 32'd3);
          mem_wr_data_q <= flt2_q[15:8];
        end
        WR3: begin
          state   <= START;
          start_q <= 1'b1;
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          cycle_ct_q <= cycle_ct_inc_c;
          // An ack edge in the timeout cycle still completes the readback
          if (ack_rise_c) begin
            state      <= RD_LO;
            mem_addr_q <= AW'(RES_BASE);
          end else if (timeout_hit_c) begin
            state         <= IDLE;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        RD_LO: begin
          state          <= RD_HI;
          result_q[7:0]  <= bus.mem_rd_data;
          mem_addr_q     <= AW'(RES_BASE + 32'd1);
        end
        RD_HI: begin
          state          <= DONE;
          result_q[15:8] <= bus.mem_rd_data;
          result_valid_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start        = start_q;
  assign bus.mem_wr_en    = mem_wr_en_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wr_data  = mem_wr_data_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.cycle_ct     = cycle_ct_q;

endmodule

// File: tb/tb_flt_op_sequencer.sv
// Bench for flt_op_sequencer: vector table, randomized runs against a
// cycle-count reference model, and reset / go-while-busy sequences.
module tb_flt_op_sequencer;
  localparam int TIMEOUT  = 100;
  localparam int OP_BASE  = 8;
  localparam int RES_BASE = 12;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic        hold;
    int          fall_at;
    int          rise_at;
    logic [15:0] exp_result;
    logic [15:0] exp_ct;
    logic        exp_terr;
  } vec_t;

  logic clk;
  logic reset;
  logic [7:0] res_lo;
  logic [7:0] res_hi;
  int checks;
  int passes;
  logic [15:0] prior;
  vec_t vecs[7];
  vec_t rv;

  flt_op_sequencer_if bus();

  flt_op_sequencer #(
    .TIMEOUT (TIMEOUT),
    .OP_BASE (OP_BASE),
    .RES_BASE(RES_BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result bytes the core model leaves in data memory
  assign bus.mem_rd_data = (bus.mem_addr == 8'(RES_BASE))     ? res_lo :
                           (bus.mem_addr == 8'(RES_BASE + 1)) ? res_hi : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " start"},        32'(bus.start),        32'd0);
    check({tag, " mem_wr_en"},    32'(bus.mem_wr_en),    32'd0);
    check({tag, " mem_addr"},     32'(bus.mem_addr),     32'd0);
    check({tag, " mem_wr_data"},  32'(bus.mem_wr_data),  32'd0);
    check({tag, " result"},       32'(bus.result),       32'd0);
    check({tag, " result_valid"}, 32'(bus.result_valid), 32'd0);
    check({tag, " busy"},         32'(bus.busy),         32'd0);
    check({tag, " timeout_err"},  32'(bus.timeout_err),  32'd0);
    check({tag, " cycle_ct"},     32'(bus.cycle_ct),     32'd0);
  endtask

  // Reference: ack edge at WAIT cycle r (r <= TIMEOUT) completes with cycle_ct = r,
  // otherwise abort after TIMEOUT WAIT cycles keeping the previous result.
  function automatic vec_t make_random(input logic [15:0] prev);
    vec_t v;
    v.a       = 16'($urandom);
    v.b       = 16'($urandom);
    v.lo      = 8'($urandom);
    v.hi      = 8'($urandom);
    v.hold    = 1'b0;
    v.fall_at = 0;
    v.rise_at = int'($urandom_range(1, TIMEOUT + 10));
    if (v.rise_at <= TIMEOUT) begin
      v.exp_result = {v.hi, v.lo};
      v.exp_ct     = 16'(v.rise_at);
      v.exp_terr   = 1'b0;
    end else begin
      v.exp_result = prev;
      v.exp_ct     = 16'(TIMEOUT);
      v.exp_terr   = 1'b1;
    end
    return v;
  endfunction

  // Runs one operation starting at a negedge in IDLE; n counts cycles from the go cycle.
  task automatic run_op(input string id, input vec_t v);
    logic [31:0] ops;
    int n, rv_cnt, rv_n, end_n;
    ops    = {v.b, v.a};
    res_lo = v.lo;
    res_hi = v.hi;
    bus.ack  = v.hold;
    bus.go   = 1'b1;
    bus.flt1 = v.a;
    bus.flt2 = v.b;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); n++;
      bus.go   = 1'($urandom_range(0, 1));
      bus.flt1 = 16'($urandom);
      bus.flt2 = 16'($urandom);
      check($sformatf("%s wr%0d en", id, k),   32'(bus.mem_wr_en),   32'd1);
      check($sformatf("%s wr%0d addr", id, k), 32'(bus.mem_addr),    32'(OP_BASE + k));
      check($sformatf("%s wr%0d data", id, k), 32'(bus.mem_wr_data), 32'(ops[8*k +: 8]));
      if (k == 0) begin
        check({id, " ct cleared"},   32'(bus.cycle_ct),    32'd0);
        check({id, " terr cleared"}, 32'(bus.timeout_err), 32'd0);
      end
    end
    @(negedge clk); n++;
    check({id, " start pulse"}, 32'(bus.start),     32'd1);
    check({id, " start wr_en"}, 32'(bus.mem_wr_en), 32'd0);
    check({id, " start addr"},  32'(bus.mem_addr),  32'd0);
    check({id, " start busy"},  32'(bus.busy),      32'd1);
    rv_cnt = 0;
    rv_n   = 0;
    while (bus.busy === 1'b1 && n < TIMEOUT + 30) begin
      if (v.fall_at != 0 && n == 5 + v.fall_at) bus.ack = 1'b0;
      if (v.rise_at != 0 && n == 5 + v.rise_at) bus.ack = 1'b1;
      @(negedge clk); n++;
      if (n == 6) check({id, " start single"}, 32'(bus.start), 32'd0);
      if (bus.result_valid === 1'b1) begin
        rv_cnt++;
        rv_n = n;
      end
      bus.go = (bus.busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    bus.go = 1'b0;
    end_n = v.exp_terr ? 6 + TIMEOUT : 9 + int'(v.exp_ct);
    check({id, " back to idle"}, 32'(bus.busy),         32'd0);
    check({id, " end cycle"},    32'(n),                32'(end_n));
    check({id, " rv pulses"},    32'(rv_cnt),           v.exp_terr ? 32'd0 : 32'd1);
    if (!v.exp_terr) check({id, " latency"}, 32'(rv_n), 32'(8 + int'(v.exp_ct)));
    check({id, " result"},       32'(bus.result),       32'(v.exp_result));
    check({id, " cycle_ct"},     32'(bus.cycle_ct),     32'(v.exp_ct));
    check({id, " timeout_err"},  32'(bus.timeout_err),  32'(v.exp_terr));
    check({id, " rv low"},       32'(bus.result_valid), 32'd0);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    res_lo = 8'h00;
    res_hi = 8'h00;
    bus.ack  = 1'b0;
    bus.flt1 = 16'h0;
    bus.flt2 = 16'h0;
    // a, b, lo, hi, hold, fall_at, rise_at, exp_result, exp_ct, exp_terr
    vecs[0] = '{16'h1A04, 16'h1A04, 8'h04, 8'h1E, 1'b0, 0, 37,  16'h1E04, 16'd37,  1'b0};
    vecs[1] = '{16'h3C00, 16'h4000, 8'h00, 8'h42, 1'b0, 0, 0,   16'h1E04, 16'd100, 1'b1};
    vecs[2] = '{16'h0001, 16'hFFFF, 8'hAA, 8'h55, 1'b0, 0, 100, 16'h55AA, 16'd100, 1'b0};
    vecs[3] = '{16'h7BFF, 16'h8001, 8'h11, 8'h22, 1'b0, 0, 101, 16'h55AA, 16'd100, 1'b1};
    vecs[4] = '{16'h1234, 16'h5678, 8'h34, 8'h12, 1'b0, 0, 1,   16'h1234, 16'd1,   1'b0};
    vecs[5] = '{16'hC000, 16'h0400, 8'hCD, 8'hAB, 1'b1, 5, 20,  16'hABCD, 16'd20,  1'b0};
    vecs[6] = '{16'h5555, 16'hAAAA, 8'h99, 8'h88, 1'b1, 0, 0,   16'hABCD, 16'd100, 1'b1};

    // Reset with go asserted: reset must win
    reset  = 1'b1;
    bus.go = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset  = 1'b0;
    bus.go = 1'b0;

    for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), vecs[i]);
    prior = vecs[6].exp_result;

    for (int i = 0; i < 6; i++) begin
      rv = make_random(prior);
      run_op($sformatf("rnd%0d", i), rv);
      prior = rv.exp_result;
    end

    // go pulsed mid-WAIT is ignored; reset mid-WAIT returns to a clean IDLE
    bus.ack  = 1'b0;
    bus.go   = 1'b1;
    bus.flt1 = 16'h2222;
    bus.flt2 = 16'h3333;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (9) @(negedge clk);
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    check("midwait busy",     32'(bus.busy),     32'd1);
    check("midwait cycle_ct", 32'(bus.cycle_ct), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("midwait reset");
    reset = 1'b0;
    @(negedge clk);
    check("midwait go ignored", 32'(bus.busy), 32'd0);
    rv = make_random(16'h0000);
    run_op("after_wait_reset", rv);
    prior = rv.exp_result;

    // Reset mid-write, with go also high in the reset cycle
    bus.go   = 1'b1;
    bus.flt1 = 16'h0F0F;
    bus.flt2 = 16'hF0F0;
    @(negedge clk);
    check("midwrite wr_en", 32'(bus.mem_wr_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("midwrite reset");
    reset  = 1'b0;
    bus.go = 1'b0;
    @(negedge clk);
    check("midwrite stays idle", 32'(bus.busy), 32'd0);
    rv = make_random(16'h0000);
    run_op("after_write_reset", rv);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
